// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB, issue and status bundle for rs_issue_queue.
// master = dispatch/CDB/execute side, slave = the reservation station.
interface rs_issue_queue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned CTL_W  = 5
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              flush;

    logic              disp_valid;
    logic              disp_ready;
    logic [CTL_W-1:0]  disp_ctl;
    logic [ROB_W-1:0]  disp_rob;
    logic [TAG_W-1:0]  disp_dst;
    logic              disp_j_rdy;
    logic [DATA_W-1:0] disp_j_val;
    logic [TAG_W-1:0]  disp_j_tag;
    logic              disp_k_rdy;
    logic [DATA_W-1:0] disp_k_val;
    logic [TAG_W-1:0]  disp_k_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              iss_valid;
    logic              iss_ready;
    logic [CTL_W-1:0]  iss_ctl;
    logic [ROB_W-1:0]  iss_rob;
    logic [TAG_W-1:0]  iss_dst;
    logic [DATA_W-1:0] iss_vj;
    logic [DATA_W-1:0] iss_vk;

    logic [OCC_W-1:0]  occupancy;

    modport master (
        output flush,
        output disp_valid, disp_ctl, disp_rob, disp_dst,
        output disp_j_rdy, disp_j_val, disp_j_tag,
        output disp_k_rdy, disp_k_val, disp_k_tag,
        input  disp_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  iss_valid, iss_ctl, iss_rob, iss_dst, iss_vj, iss_vk,
        output iss_ready,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_ctl, disp_rob, disp_dst,
        input  disp_j_rdy, disp_j_val, disp_j_tag,
        input  disp_k_rdy, disp_k_val, disp_k_tag,
        output disp_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output iss_valid, iss_ctl, iss_rob, iss_dst, iss_vj, iss_vk,
        input  iss_ready,
        output occupancy
    );
endinterface

// File: rtl/rs_issue_queue.sv
// Reservation station: captures operands from the CDB by tag, issues the oldest ready op.
// Define RS_CDB_BYPASS_EN to let a same-cycle CDB match make an entry issuable (0-cycle wakeup).
module rs_issue_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned CTL_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    rs_issue_queue_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  valid_q;
    logic [CTL_W-1:0]  ctl_q   [DEPTH];
    logic [ROB_W-1:0]  rob_q   [DEPTH];
    logic [TAG_W-1:0]  dst_q   [DEPTH];
    logic [DEPTH-1:0]  j_rdy_q;
    logic [TAG_W-1:0]  j_tag_q [DEPTH];
    logic [DATA_W-1:0] j_val_q [DEPTH];
    logic [DEPTH-1:0]  k_rdy_q;
    logic [TAG_W-1:0]  k_tag_q [DEPTH];
    logic [DATA_W-1:0] k_val_q [DEPTH];
    // age_q[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0]  age_q   [DEPTH];

    logic              cdb_hit;
    logic [DEPTH-1:0]  j_wake, k_wake;
    logic [DEPTH-1:0]  j_ok, k_ok, ready, grant;
    logic [OCC_W-1:0]  occ_cnt;
    logic [IDX_W-1:0]  free_idx, sel_idx;
    logic              disp_ready, disp_fire;
    logic              iss_valid, iss_fire;
    logic              dj_rdy, dk_rdy;
    logic [DATA_W-1:0] dj_val, dk_val;

    assign cdb_hit = bus.cdb_valid && (bus.cdb_tag != '0) && !bus.flush;

    always_comb begin
        occ_cnt  = '0;
        free_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            occ_cnt = occ_cnt + OCC_W'(valid_q[i]);
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            j_wake[i] = cdb_hit && !j_rdy_q[i] && (j_tag_q[i] == bus.cdb_tag);
            k_wake[i] = cdb_hit && !k_rdy_q[i] && (k_tag_q[i] == bus.cdb_tag);
        end
    end

`ifdef RS_CDB_BYPASS_EN
    assign j_ok = j_rdy_q | j_wake;
    assign k_ok = k_rdy_q | k_wake;
`else
    assign j_ok = j_rdy_q;
    assign k_ok = k_rdy_q;
`endif

    assign ready = valid_q & j_ok & k_ok;

    // Grant the ready entry that no other ready entry is older than.
    always_comb begin
        grant   = '0;
        sel_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic older;
            older = 1'b0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (j != i && ready[j] && age_q[j][i]) older = 1'b1;
            end
            grant[i] = ready[i] && !older;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (grant[i]) sel_idx = IDX_W'(i);
        end
    end

    assign disp_ready = rst_n && (occ_cnt < OCC_W'(DEPTH)) && !bus.flush;
    assign disp_fire  = bus.disp_valid && disp_ready;
    assign iss_valid  = rst_n && !bus.flush && (|ready);
    assign iss_fire   = iss_valid && bus.iss_ready;

    assign bus.disp_ready = disp_ready;
    assign bus.iss_valid  = iss_valid;
    assign bus.occupancy  = rst_n ? occ_cnt : '0;
    assign bus.iss_ctl    = iss_valid ? ctl_q[sel_idx] : '0;
    assign bus.iss_rob    = iss_valid ? rob_q[sel_idx] : '0;
    assign bus.iss_dst    = iss_valid ? dst_q[sel_idx] : '0;
    // A selected entry with a missing operand can only be a bypass hit.
    assign bus.iss_vj = !iss_valid ? '0 : j_rdy_q[sel_idx] ? j_val_q[sel_idx] : bus.cdb_data;
    assign bus.iss_vk = !iss_valid ? '0 : k_rdy_q[sel_idx] ? k_val_q[sel_idx] : bus.cdb_data;

    // Dispatching operands: tag 0 is $zero, otherwise capture a colliding broadcast.
    always_comb begin
        dj_rdy = 1'b1;
        dj_val = '0;
        if (bus.disp_j_tag != '0) begin
            dj_rdy = bus.disp_j_rdy || (cdb_hit && bus.disp_j_tag == bus.cdb_tag);
            dj_val = (!bus.disp_j_rdy && cdb_hit && bus.disp_j_tag == bus.cdb_tag) ?
                     bus.cdb_data : bus.disp_j_val;
        end
        dk_rdy = 1'b1;
        dk_val = '0;
        if (bus.disp_k_tag != '0) begin
            dk_rdy = bus.disp_k_rdy || (cdb_hit && bus.disp_k_tag == bus.cdb_tag);
            dk_val = (!bus.disp_k_rdy && cdb_hit && bus.disp_k_tag == bus.cdb_tag) ?
                     bus.cdb_data : bus.disp_k_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && j_wake[i]) begin
                    j_rdy_q[i] <= 1'b1;
                    j_val_q[i] <= bus.cdb_data;
                end
                if (valid_q[i] && k_wake[i]) begin
                    k_rdy_q[i] <= 1'b1;
                    k_val_q[i] <= bus.cdb_data;
                end
            end
            if (iss_fire) valid_q[sel_idx] <= 1'b0;
            if (disp_fire) begin
                valid_q[free_idx] <= 1'b1;
                ctl_q[free_idx]   <= bus.disp_ctl;
                rob_q[free_idx]   <= bus.disp_rob;
                dst_q[free_idx]   <= bus.disp_dst;
                j_rdy_q[free_idx] <= dj_rdy;
                j_tag_q[free_idx] <= bus.disp_j_tag;
                j_val_q[free_idx] <= dj_val;
                k_rdy_q[free_idx] <= dk_rdy;
                k_tag_q[free_idx] <= bus.disp_k_tag;
                k_val_q[free_idx] <= dk_val;
                // Newcomer is younger than everything already present.
                age_q[free_idx]   <= '0;
                for (int j = 0; j < int'(DEPTH); j++) begin
                    if (j != int'(free_idx)) age_q[j][free_idx] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue; expected issues are queued at dispatch/broadcast
// time and compared in order as the DUT issues.
module tb_rs_issue_queue;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned ROB_W  = 4;
    localparam int unsigned CTL_W  = 5;
`ifdef RS_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    rs_issue_queue_if #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W), .CTL_W(CTL_W)
    ) bus ();

    rs_issue_queue #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ROB_W(ROB_W), .CTL_W(CTL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [CTL_W-1:0]  ctl;
        logic [ROB_W-1:0]  rob;
        logic [TAG_W-1:0]  dst;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    function automatic exp_t mk(input int ctl, input int rob, input int dst,
                                input logic [31:0] vj, input logic [31:0] vk);
        exp_t e;
        e.ctl = CTL_W'(ctl);
        e.rob = ROB_W'(rob);
        e.dst = TAG_W'(dst);
        e.vj  = vj;
        e.vk  = vk;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Finish the current cycle: check any issue against the scoreboard, advance to next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (bus.iss_valid && bus.iss_ready) begin
            n_total++;
            assert (sb.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL unexpected_issue: observed rob %0d expected no issue", bus.iss_rob);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("issue", 96'({bus.iss_ctl, bus.iss_rob, bus.iss_dst, bus.iss_vj, bus.iss_vk}),
                    96'(e));
            end
        end
        @(negedge clk);
    endtask

    task automatic disp(input int ctl, input int rob, input int dst,
                        input logic jr, input logic [31:0] jv, input int jt,
                        input logic kr, input logic [31:0] kv, input int kt);
        bus.disp_valid = 1'b1;
        bus.disp_ctl   = CTL_W'(ctl);
        bus.disp_rob   = ROB_W'(rob);
        bus.disp_dst   = TAG_W'(dst);
        bus.disp_j_rdy = jr;
        bus.disp_j_val = jv;
        bus.disp_j_tag = TAG_W'(jt);
        bus.disp_k_rdy = kr;
        bus.disp_k_val = kv;
        bus.disp_k_tag = TAG_W'(kt);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        bus.flush      = 1'b0;
        #1;
    endtask

    task automatic cdb(input int tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = TAG_W'(tag);
        bus.cdb_data  = data;
        #1;
    endtask

    task automatic drain(input int budget);
        bus.iss_ready = 1'b1;
        #1;
        for (int c = 0; c < budget && sb.size() != 0; c++) tick();
        chk("drain_empty", 96'(sb.size()), 96'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.iss_ready = 1'b0;
        bus.cdb_tag = '0;
        bus.cdb_data = '0;
        disp(0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        idle();
        @(negedge clk);
        tick();
        chk("reset_occ", 96'(bus.occupancy), 96'(0));
        chk("reset_disp_ready", 96'(bus.disp_ready), 96'(0));
        chk("reset_iss_valid", 96'(bus.iss_valid), 96'(0));
        rst_n = 1'b1;
        tick();
        chk("post_reset_disp_ready", 96'(bus.disp_ready), 96'(1));
        chk("post_reset_iss_rob", 96'(bus.iss_rob), 96'(0));

        // Fill with ready ops, execute stage stalled.
        for (int i = 0; i < 8; i++) begin
            disp(i + 1, i, i + 8, 1'b1, 32'h100 + 32'(i), 10 + i, 1'b1, 32'h200 + 32'(i), 20 + i);
            sb.push_back(mk(i + 1, i, i + 8, 32'h100 + 32'(i), 32'h200 + 32'(i)));
            tick();
        end
        disp(31, 15, 60, 1'b1, 32'hFFFF, 40, 1'b1, 32'hFFFF, 41);
        chk("full_occ", 96'(bus.occupancy), 96'(8));
        chk("full_disp_ready", 96'(bus.disp_ready), 96'(0));
        chk("oldest_rob", 96'(bus.iss_rob), 96'(0));
        tick();
        idle();
        chk("ninth_dropped", 96'(bus.occupancy), 96'(8));
        cdb(0, 32'hDEAD);
        tick();
        idle();
        chk("tag0_vj", 96'(bus.iss_vj), 96'(32'h100));
        chk("tag0_occ", 96'(bus.occupancy), 96'(8));

        // Issue from full is not credited to dispatch; next cycle both fire.
        disp(9, 9, 17, 1'b1, 32'h900, 30, 1'b1, 32'h901, 31);
        bus.iss_ready = 1'b1;
        #1;
        chk("full_issue_disp_ready", 96'(bus.disp_ready), 96'(0));
        tick();
        chk("after_issue_occ", 96'(bus.occupancy), 96'(7));
        chk("freed_disp_ready", 96'(bus.disp_ready), 96'(1));
        sb.push_back(mk(9, 9, 17, 32'h900, 32'h901));
        tick();
        idle();
        chk("disp_iss_same_occ", 96'(bus.occupancy), 96'(7));
        drain(20);
        chk("drained_occ", 96'(bus.occupancy), 96'(0));
        chk("drained_iss_valid", 96'(bus.iss_valid), 96'(0));

        // Back-to-back dispatch and issue, in age order.
        for (int i = 1; i <= 3; i++) begin
            disp(i, i, 40 + i, 1'b1, 32'h10 * 32'(i), 50 + i, 1'b1, 32'h20 * 32'(i), 55);
            sb.push_back(mk(i, i, 40 + i, 32'h10 * 32'(i), 32'h20 * 32'(i)));
            chk("b2b_rob", 96'(bus.iss_rob), 96'(i - 1));
            tick();
        end
        idle();
        chk("b2b_last_valid", 96'(bus.iss_valid), 96'(1));
        tick();
        chk("b2b_done", 96'(bus.iss_valid), 96'(0));

        // A waits on tag 5 (k tag 0 forces vk=0); younger ready B goes first.
        bus.iss_ready = 1'b0;
        disp(2, 4, 33, 1'b0, 32'hAAAA, 5, 1'b1, 32'h55, 0);
        tick();
        disp(3, 5, 34, 1'b1, 32'h11, 12, 1'b1, 32'h22, 13);
        sb.push_back(mk(3, 5, 34, 32'h11, 32'h22));
        chk("a_not_ready", 96'(bus.iss_valid), 96'(0));
        tick();
        idle();
        chk("b_first", 96'(bus.iss_rob), 96'(5));
        bus.iss_ready = 1'b1;
        tick();
        chk("a_waiting", 96'(bus.iss_valid), 96'(0));
        cdb(5, 32'h1234);
        sb.push_back(mk(2, 4, 33, 32'h1234, 32'h0));
        chk("wake_same_cycle", 96'(bus.iss_valid), 96'(BYPASS));
        tick();
        idle();
        chk("wake_latency_occ", 96'(bus.occupancy), 96'(BYPASS ? 0 : 1));
        drain(4);

        // Dispatch colliding with a matching broadcast captures the value.
        bus.iss_ready = 1'b0;
        disp(4, 6, 35, 1'b0, 32'h0, 7, 1'b1, 32'h3, 14);
        cdb(7, 32'hBEEF);
        sb.push_back(mk(4, 6, 35, 32'hBEEF, 32'h3));
        tick();
        idle();
        chk("collision_ready", 96'(bus.iss_valid), 96'(1));
        chk("collision_vj", 96'(bus.iss_vj), 96'(32'hBEEF));
        drain(4);

        // Flush with five entries, dispatch/CDB/issue all suppressed.
        bus.iss_ready = 1'b0;
        disp(5, 7, 36, 1'b0, 32'h0, 9, 1'b1, 32'h1, 15);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            disp(6, 8 + i, 20 + i, 1'b1, 32'h5, 16, 1'b1, 32'h6, 17);
            tick();
        end
        idle();
        chk("pre_flush_occ", 96'(bus.occupancy), 96'(5));
        bus.flush = 1'b1;
        bus.iss_ready = 1'b1;
        cdb(9, 32'h77);
        disp(7, 12, 25, 1'b1, 32'h8, 18, 1'b1, 32'h9, 19);
        chk("flush_iss_valid", 96'(bus.iss_valid), 96'(0));
        chk("flush_disp_ready", 96'(bus.disp_ready), 96'(0));
        tick();
        idle();
        chk("flush_occ", 96'(bus.occupancy), 96'(0));
        tick();
        chk("flush_stays_empty", 96'(bus.iss_valid), 96'(0));

        // Reset in the middle of traffic.
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(8, 12 + i, 26 + i, 1'b1, 32'h31, 18, 1'b1, 32'h32, 19);
            tick();
        end
        idle();
        chk("pre_reset_occ", 96'(bus.occupancy), 96'(3));
        rst_n = 1'b0;
        #1;
        chk("in_reset_disp_ready", 96'(bus.disp_ready), 96'(0));
        chk("in_reset_iss_valid", 96'(bus.iss_valid), 96'(0));
        tick();
        chk("in_reset_occ", 96'(bus.occupancy), 96'(0));
        chk("in_reset_iss_vj", 96'(bus.iss_vj), 96'(0));
        rst_n = 1'b1;
        tick();
        chk("after_reset_occ", 96'(bus.occupancy), 96'(0));
        chk("after_reset_iss_valid", 96'(bus.iss_valid), 96'(0));

        bus.iss_ready = 1'b1;
        disp(10, 15, 63, 1'b1, 32'hCAFE, 3, 1'b1, 32'hF00D, 4);
        sb.push_back(mk(10, 15, 63, 32'hCAFE, 32'hF00D));
        tick();
        idle();
        drain(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
